// File: rtl/crc_fsk_link_ctrl.sv
// rtl/crc_fsk_link_ctrl.sv - CRC framed serial TX/RX link controller with error injection and stats
// TX serialises {data,crc} one bit per symbol; RX deserialises, re-checks CRC and counts frames.
module crc_fsk_link_ctrl #(
   parameter int                 DATA_W     = 8,
   parameter int                 CRC_W      = 8,
   parameter logic [CRC_W-1:0]   POLY       = 8'h07,
   parameter logic [CRC_W-1:0]   INIT       = 8'h00,
   parameter int                 SYM_CYCLES = 256,
   parameter int                 CNT_W      = 16
) (
   input  logic                              sys_clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_W-1:0]                 in_data,
   input  logic                              inj_en,
   input  logic [$clog2(DATA_W+CRC_W)-1:0]   inj_pos,
   output logic                              tx_bit,
   output logic                              tx_sym_start,
   output logic                              tx_busy,
   input  logic                              rx_bit,
   input  logic                              rx_bit_valid,
   input  logic                              rx_sof,
   output logic                              out_valid,
   output logic [DATA_W-1:0]                 out_data,
   output logic                              out_crc_ok,
   output logic [CNT_W-1:0]                  frame_cnt,
   output logic [CNT_W-1:0]                  err_cnt
);

   localparam int N      = DATA_W + CRC_W;
   localparam int IDX_W  = $clog2(N);
   localparam int CYC_W  = $clog2(SYM_CYCLES);
   localparam int RCNT_W = $clog2(N + 1);

   typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_CRC} tx_state_t;
   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
      logic fb;
      fb = c[CRC_W-1] ^ b;
      crc_step = (c << 1) ^ (fb ? POLY : '0);
   endfunction

   tx_state_t          tx_state_q, tx_state_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [CRC_W-1:0]   tx_crc_q, tx_crc_d;
   logic [CYC_W-1:0]   tx_cyc_q, tx_cyc_d;
   logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
   logic               inj_en_q, inj_en_d;
   logic [IDX_W-1:0]   inj_pos_q, inj_pos_d;
   logic               tx_bit_q, tx_bit_d;
   logic               tx_sym_start_q, tx_sym_start_d;
   logic               tx_busy_q, tx_busy_d;
   logic               in_ready_q, in_ready_d;
   logic               tx_nb;

   rx_state_t          rx_state_q, rx_state_d;
   logic [DATA_W-1:0]  rx_data_q, rx_data_d;
   logic [CRC_W-1:0]   rx_crc_q, rx_crc_d;
   logic [RCNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_crc_ok_q, out_crc_ok_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   // tx_bit is computed one cycle ahead so each symbol's value is registered at its first cycle.
   always_comb begin
      tx_state_d     = tx_state_q;
      tx_data_d      = tx_data_q;
      tx_crc_d       = tx_crc_q;
      tx_cyc_d       = tx_cyc_q;
      tx_idx_d       = tx_idx_q;
      inj_en_d       = inj_en_q;
      inj_pos_d      = inj_pos_q;
      tx_bit_d       = tx_bit_q;
      tx_sym_start_d = 1'b0;
      tx_busy_d      = tx_busy_q;
      in_ready_d     = in_ready_q;
      tx_nb          = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (in_valid) begin
               tx_state_d     = TX_DATA;
               tx_data_d      = in_data;
               tx_crc_d       = INIT;
               tx_cyc_d       = '0;
               tx_idx_d       = '0;
               inj_en_d       = inj_en;
               inj_pos_d      = inj_pos;
               tx_bit_d       = in_data[DATA_W-1] ^ (inj_en && (inj_pos == '0));
               tx_sym_start_d = 1'b1;
               tx_busy_d      = 1'b1;
               in_ready_d     = 1'b0;
            end
         end
         TX_DATA, TX_CRC: begin
            if (tx_cyc_q == CYC_W'(SYM_CYCLES - 1)) begin
               tx_cyc_d = '0;
               tx_idx_d = tx_idx_q + 1'b1;
               if (tx_state_q == TX_DATA) begin
                  tx_crc_d  = crc_step(tx_crc_q, tx_data_q[DATA_W-1]);
                  tx_data_d = tx_data_q << 1;
                  if (tx_idx_q == IDX_W'(DATA_W - 1)) begin
                     tx_state_d = TX_CRC;
                     tx_nb      = tx_crc_d[CRC_W-1];
                  end else begin
                     tx_nb = tx_data_d[DATA_W-1];
                  end
               end else begin
                  tx_crc_d = tx_crc_q << 1;
                  tx_nb    = tx_crc_d[CRC_W-1];
               end
               if (tx_state_q == TX_CRC && tx_idx_q == IDX_W'(N - 1)) begin
                  tx_state_d = TX_IDLE;
                  tx_bit_d   = 1'b0;
                  tx_busy_d  = 1'b0;
                  in_ready_d = 1'b1;
               end else begin
                  tx_bit_d       = tx_nb ^ (inj_en_q && (inj_pos_q == tx_idx_d));
                  tx_sym_start_d = 1'b1;
               end
            end else begin
               tx_cyc_d = tx_cyc_q + 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_data_d    = rx_data_q;
      rx_crc_d     = rx_crc_q;
      rx_cnt_d     = rx_cnt_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_crc_ok_d = out_crc_ok_q;
      frame_cnt_d  = frame_cnt_q;
      err_cnt_d    = err_cnt_q;
      if (rx_bit_valid && rx_sof) begin
         rx_state_d = RX_SHIFT;
         rx_crc_d   = crc_step(INIT, rx_bit);
         rx_data_d  = DATA_W'(rx_bit);
         rx_cnt_d   = RCNT_W'(1);
      end else if (rx_bit_valid && rx_state_q == RX_SHIFT) begin
         rx_crc_d = crc_step(rx_crc_q, rx_bit);
         rx_cnt_d = rx_cnt_q + 1'b1;
         if (rx_cnt_q < RCNT_W'(DATA_W)) begin
            rx_data_d = (rx_data_q << 1) | DATA_W'(rx_bit);
         end
         if (rx_cnt_q == RCNT_W'(N - 1)) begin
            rx_state_d   = RX_IDLE;
            out_valid_d  = 1'b1;
            out_data_d   = rx_data_d;
            out_crc_ok_d = (rx_crc_d == '0);
            if (frame_cnt_q != '1) begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if (rx_crc_d != '0 && err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         tx_state_q     <= TX_IDLE;
         tx_data_q      <= '0;
         tx_crc_q       <= '0;
         tx_cyc_q       <= '0;
         tx_idx_q       <= '0;
         inj_en_q       <= 1'b0;
         inj_pos_q      <= '0;
         tx_bit_q       <= 1'b0;
         tx_sym_start_q <= 1'b0;
         tx_busy_q      <= 1'b0;
         in_ready_q     <= 1'b1;
         rx_state_q     <= RX_IDLE;
         rx_data_q      <= '0;
         rx_crc_q       <= '0;
         rx_cnt_q       <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_crc_ok_q   <= 1'b0;
         frame_cnt_q    <= '0;
         err_cnt_q      <= '0;
      end else begin
         tx_state_q     <= tx_state_d;
         tx_data_q      <= tx_data_d;
         tx_crc_q       <= tx_crc_d;
         tx_cyc_q       <= tx_cyc_d;
         tx_idx_q       <= tx_idx_d;
         inj_en_q       <= inj_en_d;
         inj_pos_q      <= inj_pos_d;
         tx_bit_q       <= tx_bit_d;
         tx_sym_start_q <= tx_sym_start_d;
         tx_busy_q      <= tx_busy_d;
         in_ready_q     <= in_ready_d;
         rx_state_q     <= rx_state_d;
         rx_data_q      <= rx_data_d;
         rx_crc_q       <= rx_crc_d;
         rx_cnt_q       <= rx_cnt_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_crc_ok_q   <= out_crc_ok_d;
         frame_cnt_q    <= frame_cnt_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign tx_bit       = tx_bit_q;
   assign tx_sym_start = tx_sym_start_q;
   assign tx_busy      = tx_busy_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_crc_ok   = out_crc_ok_q;
   assign frame_cnt    = frame_cnt_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_crc_fsk_link_ctrl.sv
// tb/tb_crc_fsk_link_ctrl.sv - directed loopback bench for crc_fsk_link_ctrl
module tb_crc_fsk_link_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, inj_en;
   logic [7:0]  in_data;
   logic [3:0]  inj_pos;
   logic        tx_bit, tx_sym_start, tx_busy, in_ready, out_valid, out_crc_ok;
   logic [7:0]  out_data;
   logic [15:0] frame_cnt, err_cnt;

   logic        loop_en;
   logic        lb_valid, lb_sof, lb_bit;
   logic        man_valid, man_sof, man_bit;
   logic        rx_bit, rx_bit_valid, rx_sof;
   assign rx_bit       = loop_en ? lb_bit   : man_bit;
   assign rx_bit_valid = loop_en ? lb_valid : man_valid;
   assign rx_sof       = loop_en ? lb_sof   : man_sof;

   logic        d2_tx_bit, d2_tx_sym_start, d2_tx_busy, d2_in_ready, d2_out_valid, d2_out_crc_ok;
   logic [7:0]  d2_out_data;
   logic [1:0]  d2_frame_cnt, d2_err_cnt;

   crc_fsk_link_ctrl #(.SYM_CYCLES(4)) dut (
      .sys_clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos), .tx_bit(tx_bit),
      .tx_sym_start(tx_sym_start), .tx_busy(tx_busy), .rx_bit(rx_bit),
      .rx_bit_valid(rx_bit_valid), .rx_sof(rx_sof), .out_valid(out_valid),
      .out_data(out_data), .out_crc_ok(out_crc_ok), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   crc_fsk_link_ctrl #(.SYM_CYCLES(4), .CNT_W(2)) dut2 (
      .sys_clk(clk), .rst_n(rst_n), .in_valid(1'b0), .in_ready(d2_in_ready),
      .in_data(8'h00), .inj_en(1'b0), .inj_pos(4'd0), .tx_bit(d2_tx_bit),
      .tx_sym_start(d2_tx_sym_start), .tx_busy(d2_tx_busy), .rx_bit(man_bit),
      .rx_bit_valid(man_valid), .rx_sof(man_sof), .out_valid(d2_out_valid),
      .out_data(d2_out_data), .out_crc_ok(d2_out_crc_ok), .frame_cnt(d2_frame_cnt), .err_cnt(d2_err_cnt)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] cap = 16'h0;
   int          ov_cnt = 0;
   logic [7:0]  last_data;
   logic        last_crc;
   logic [15:0] last_cap;

   // Loopback: strobe rx one cycle into each symbol, SOF on the first symbol after idle.
   initial begin
      logic pend, pend_sof, prev_busy;
      pend = 1'b0; pend_sof = 1'b0; prev_busy = 1'b0;
      lb_valid = 1'b0; lb_sof = 1'b0; lb_bit = 1'b0;
      forever begin
         @(negedge clk);
         lb_valid = 1'b0;
         lb_sof   = 1'b0;
         if (pend) begin
            lb_valid = 1'b1;
            lb_bit   = tx_bit;
            lb_sof   = pend_sof;
            pend     = 1'b0;
         end
         if (tx_sym_start) begin
            pend     = 1'b1;
            pend_sof = !prev_busy;
            cap      = {cap[14:0], tx_bit};
         end
         prev_busy = tx_busy;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (out_valid) begin
            last_data = out_data;
            last_crc  = out_crc_ok;
            last_cap  = cap;
            ov_cnt    = ov_cnt + 1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] d, input logic e, input logic [3:0] p);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      in_valid = 1'b1; in_data = d; inj_en = e; inj_pos = p;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_data = 8'h55; inj_en = 1'b0; inj_pos = 4'd0;
   endtask

   task automatic wait_out(input string name, input int ov0);
      int k;
      k = 0;
      while (ov_cnt <= ov0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (ov_cnt <= ov0) begin
         n_bad++;
         $display("FAIL %s: out_valid timeout, got %0d pulses, required %0d", name, ov_cnt - ov0, 1);
      end
   endtask

   task automatic man_send(input logic [15:0] w, input int nb);
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         man_valid = 1'b1; man_bit = w[15-i]; man_sof = (i == 0);
         @(negedge clk);
         man_valid = 1'b0; man_sof = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input string name, input logic [7:0] ed, input logic ec, input logic [15:0] ecap);
      n_cmp++;
      if (last_data !== ed) begin n_bad++; $display("FAIL %s data: got %h required %h", name, last_data, ed); end
      n_cmp++;
      if (last_crc !== ec) begin n_bad++; $display("FAIL %s crc_ok: got %b required %b", name, last_crc, ec); end
      n_cmp++;
      if (last_cap !== ecap) begin n_bad++; $display("FAIL %s stream: got %h required %h", name, last_cap, ecap); end
   endtask

   task automatic check_cnt(input string name, input logic [15:0] ef, input logic [15:0] ee);
      n_cmp++;
      if (frame_cnt !== ef) begin n_bad++; $display("FAIL %s frame_cnt: got %0d required %0d", name, frame_cnt, ef); end
      n_cmp++;
      if (err_cnt !== ee) begin n_bad++; $display("FAIL %s err_cnt: got %0d required %0d", name, err_cnt, ee); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; inj_en = 1'b0; inj_pos = 4'd0;
      loop_en = 1'b1; man_valid = 1'b0; man_sof = 1'b0; man_bit = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
      n_cmp++;
      if ({tx_bit, tx_sym_start, tx_busy, out_valid, out_crc_ok} !== 5'b0) begin
         n_bad++; $display("FAIL reset flags: got %b required 00000", {tx_bit, tx_sym_start, tx_busy, out_valid, out_crc_ok});
      end
      n_cmp++;
      if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset out_data: got %h required 00", out_data); end
      check_cnt("reset", 16'd0, 16'd0);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int ov0;
      ov0 = ov_cnt;
      send(8'hBB, 1'b0, 4'd0);
      wait_out("basic", ov0);
      check_frame("basic", 8'hBB, 1'b1, 16'hBB28);
      check_cnt("basic", 16'd1, 16'd0);
   endtask

   task automatic test_back_to_back();
      int ov0, n;
      logic seen;
      logic [7:0] f_data;
      logic f_crc;
      logic [15:0] f_cap;
      ov0 = ov_cnt; n = 0; seen = 1'b0; f_data = 8'h00; f_crc = 1'b0; f_cap = 16'h0;
      @(negedge clk);
      while (!in_ready) @(negedge clk);
      in_valid = 1'b1; in_data = 8'hF0;
      @(posedge clk);
      #1;
      in_data = 8'hBB;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n++;
         if (ov_cnt == ov0 + 1 && !seen) begin
            seen = 1'b1; f_data = last_data; f_crc = last_crc; f_cap = last_cap;
         end
         if (in_ready) break;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++;
      if (n !== 65) begin n_bad++; $display("FAIL b2b frame period: got %0d cycles required 65", n); end
      n_cmp++;
      if (seen !== 1'b1) begin n_bad++; $display("FAIL b2b first out_valid: got %b required 1", seen); end
      n_cmp++;
      if (f_data !== 8'hF0) begin n_bad++; $display("FAIL b2b F0 data: got %h required f0", f_data); end
      n_cmp++;
      if (f_crc !== 1'b1) begin n_bad++; $display("FAIL b2b F0 crc_ok: got %b required 1", f_crc); end
      n_cmp++;
      if (f_cap !== 16'hF0DE) begin n_bad++; $display("FAIL b2b F0 stream: got %h required f0de", f_cap); end
      wait_out("b2b second", ov0 + 1);
      check_frame("b2b BB", 8'hBB, 1'b1, 16'hBB28);
      check_cnt("b2b", 16'd3, 16'd0);
   endtask

   task automatic test_inject();
      int ov0;
      ov0 = ov_cnt;
      send(8'hBB, 1'b1, 4'd3);
      wait_out("inj3", ov0);
      check_frame("inj3", 8'hAB, 1'b0, 16'hAB28);
      check_cnt("inj3", 16'd4, 16'd1);
      ov0 = ov_cnt;
      send(8'hBB, 1'b1, 4'd15);
      wait_out("inj15", ov0);
      check_frame("inj15", 8'hBB, 1'b0, 16'hBB29);
      check_cnt("inj15", 16'd5, 16'd2);
   endtask

   task automatic test_sof_abort();
      int ov0;
      @(negedge clk);
      while (!in_ready) @(negedge clk);
      repeat (4) @(negedge clk);
      loop_en = 1'b0;
      ov0 = ov_cnt;
      man_send(16'hBB28, 5);
      man_send(16'hF0DE, 16);
      wait_out("sof_abort", ov0);
      repeat (60) @(negedge clk);
      n_cmp++;
      if (ov_cnt - ov0 !== 1) begin n_bad++; $display("FAIL sof_abort pulses: got %0d required 1", ov_cnt - ov0); end
      n_cmp++;
      if (last_data !== 8'hF0) begin n_bad++; $display("FAIL sof_abort data: got %h required f0", last_data); end
      n_cmp++;
      if (last_crc !== 1'b1) begin n_bad++; $display("FAIL sof_abort crc_ok: got %b required 1", last_crc); end
      check_cnt("sof_abort", 16'd6, 16'd2);
      loop_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int ov0;
      send(8'hBB, 1'b0, 4'd0);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid busy before: got %b required 1", tx_busy); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({tx_bit, tx_busy, in_ready} !== 3'b001) begin
         n_bad++; $display("FAIL rst_mid tx: got %b required 001", {tx_bit, tx_busy, in_ready});
      end
      check_cnt("rst_mid", 16'd0, 16'd0);
      rst_n = 1'b1;
      ov0 = ov_cnt;
      repeat (80) @(negedge clk);
      n_cmp++;
      if (ov_cnt !== ov0) begin n_bad++; $display("FAIL rst_mid stray out_valid: got %0d required 0", ov_cnt - ov0); end
      check_cnt("rst_mid after", 16'd0, 16'd0);
   endtask

   task automatic test_saturation();
      loop_en = 1'b0;
      man_send(16'hBB29, 16);
      man_send(16'hBB29, 16);
      n_cmp++;
      if ({d2_frame_cnt, d2_err_cnt} !== 4'b1010) begin
         n_bad++; $display("FAIL sat two frames: got %0d/%0d required 2/2", d2_frame_cnt, d2_err_cnt);
      end
      man_send(16'hBB29, 16);
      man_send(16'hBB29, 16);
      n_cmp++;
      if (d2_frame_cnt !== 2'd3) begin n_bad++; $display("FAIL sat frame_cnt: got %0d required 3", d2_frame_cnt); end
      n_cmp++;
      if (d2_err_cnt !== 2'd3) begin n_bad++; $display("FAIL sat err_cnt: got %0d required 3", d2_err_cnt); end
      loop_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_inject();
      test_sof_abort();
      test_reset_mid();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
